// File: rtl/sd_resp_pkg.sv
// Shared definitions for the SD data-response token receiver.
package sd_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        STATUS,
        END_BIT,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] RESP_ACCEPTED = 3'b010;
    localparam logic [2:0] RESP_CRC_ERR  = 3'b101;
    localparam logic [2:0] RESP_WR_ERR   = 3'b110;

    typedef struct packed {
        logic accepted;
        logic crc_err;
        logic write_err;
        logic frame_err;
    } resp_flags_t;

    // Map a captured token status onto exactly one decode flag.
    function automatic resp_flags_t decode_status(input logic [2:0] s);
        resp_flags_t f;
        f = '0;
        case (s)
            RESP_ACCEPTED: f.accepted  = 1'b1;
            RESP_CRC_ERR:  f.crc_err   = 1'b1;
            RESP_WR_ERR:   f.write_err = 1'b1;
            default:       f.frame_err = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/counter.sv
// Saturating up-counter used for the waiting-phase timeout.
module counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Clear has priority; counting stops at all ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sd_dat_resp_rx.sv
// SD DAT0 write-response token receiver: start bit, 3 status bits, end bit,
// optional busy phase, with per-phase timeout. All outputs are registered.
module sd_dat_resp_rx
    import sd_resp_pkg::*;
#(
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned BUSY_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dat_in,
    input  logic [TMO_W-1:0] timeout_limit,
    output logic             done,
    output logic [2:0]       status,
    output logic             accepted,
    output logic             crc_err,
    output logic             write_err,
    output logic             frame_err,
    output logic             timeout_err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [2:0]       status_q, status_d;
    logic [1:0]       idx_q, idx_d;
    logic             en_q;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    resp_flags_t      flags_q, flags_d;
    resp_flags_t      dec;
    logic             cnt_clr, cnt_en;
    logic [TMO_W-1:0] cnt;
    logic             tmo_hit;

    counter #(.W(TMO_W)) u_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clr),
        .en    (cnt_en),
        .count (cnt)
    );

    assign dec     = decode_status(status_q);
    assign tmo_hit = (timeout_limit != '0) && (cnt == timeout_limit);

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            status_q <= '0;
            idx_q    <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            idx_q    <= idx_d;
            en_q     <= enable;
            done_q   <= done_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
            flags_q  <= flags_d;
        end
    end

    // Next-state and next-output logic; enable low overrides everything.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        idx_d    = idx_q;
        done_d   = done_q;
        busy_d   = 1'b0;
        tmo_d    = tmo_q;
        flags_d  = flags_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        if ((state_q != IDLE) && !enable) begin
            state_d  = IDLE;
            status_d = '0;
            done_d   = 1'b0;
            tmo_d    = 1'b0;
            flags_d  = '0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (enable && !en_q) begin
                        state_d  = WAIT_START;
                        status_d = '0;
                        done_d   = 1'b0;
                        tmo_d    = 1'b0;
                        flags_d  = '0;
                    end
                end
                WAIT_START: begin
                    if (!dat_in) begin
                        state_d = STATUS;
                        idx_d   = '0;
                    end else if (tmo_hit) begin
                        state_d = DONE;
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                STATUS: begin
                    status_d = {status_q[1:0], dat_in};
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd2) begin
                        state_d = END_BIT;
                    end
                end
                END_BIT: begin
                    if (!dat_in) begin
                        state_d           = DONE;
                        flags_d           = '0;
                        flags_d.frame_err = 1'b1;
                        done_d            = 1'b1;
                    end else if (BUSY_EN != 0) begin
                        state_d = BUSY;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = DONE;
                        flags_d = dec;
                        done_d  = 1'b1;
                    end
                end
                BUSY: begin
                    if (dat_in) begin
                        state_d = DONE;
                        flags_d = dec;
                        done_d  = 1'b1;
                    end else if (tmo_hit) begin
                        state_d = DONE;
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        cnt_en = 1'b1;
                    end
                end
                DONE: begin
                    // Results hold until enable drops (handled above).
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign done        = done_q;
    assign status      = status_q;
    assign accepted    = flags_q.accepted;
    assign crc_err     = flags_q.crc_err;
    assign write_err   = flags_q.write_err;
    assign frame_err   = flags_q.frame_err;
    assign timeout_err = tmo_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sd_dat_resp_rx.sv
// Self-checking bench for sd_dat_resp_rx: fixed vector table, randomized
// frames against a reference model, and hand-written abort/reset sequences.
module tb_sd_dat_resp_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        dat_in;
    logic [15:0] timeout_limit;
    logic        done;
    logic [2:0]  status;
    logic        accepted, crc_err, write_err, frame_err, timeout_err, busy;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int         d;          // idle-high cycles before the start bit
        logic [2:0] s;          // token status bits
        logic       e;          // end bit
        int         b;          // busy-low cycles
        int         lim;        // timeout_limit
        logic [4:0] exp_flags;  // {accepted,crc_err,write_err,frame_err,timeout_err}
        logic [2:0] exp_status;
        int         exp_busy;   // cycles with busy high
        int         exp_done;   // edge index (enable edge = 0) at which done rises
    } vec_t;

    sd_dat_resp_rx #(.TMO_W(16), .BUSY_EN(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .dat_in        (dat_in),
        .timeout_limit (timeout_limit),
        .done          (done),
        .status        (status),
        .accepted      (accepted),
        .crc_err       (crc_err),
        .write_err     (write_err),
        .frame_err     (frame_err),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({done, status, accepted, crc_err, write_err, frame_err, timeout_err, busy});
    endfunction

    function automatic vec_t mk(int d, logic [2:0] s, logic e, int b, int lim,
                                logic [4:0] fl, logic [2:0] st, int bc, int de);
        vec_t v;
        v.d = d; v.s = s; v.e = e; v.b = b; v.lim = lim;
        v.exp_flags = fl; v.exp_status = st; v.exp_busy = bc; v.exp_done = de;
        return v;
    endfunction

    // Reference model: outcome of one frame from the protocol rules.
    function automatic vec_t model(int d, logic [2:0] s, logic e, int b, int lim);
        vec_t v;
        v = mk(d, s, e, b, lim, '0, '0, 0, 0);
        if (lim != 0 && d > lim) begin
            v.exp_flags = 5'b00001; v.exp_status = 3'b000;
            v.exp_busy = 0; v.exp_done = lim + 1;
        end else if (!e) begin
            v.exp_flags = 5'b00010; v.exp_status = s;
            v.exp_busy = 0; v.exp_done = d + 5;
        end else if (lim != 0 && b > lim) begin
            v.exp_flags = 5'b00001; v.exp_status = s;
            v.exp_busy = lim; v.exp_done = d + 6 + lim;
        end else begin
            v.exp_status = s;
            v.exp_busy = b; v.exp_done = d + 6 + b;
            if (s == 3'b010)      v.exp_flags = 5'b10000;
            else if (s == 3'b101) v.exp_flags = 5'b01000;
            else if (s == 3'b110) v.exp_flags = 5'b00100;
            else                  v.exp_flags = 5'b00010;
        end
        return v;
    endfunction

    // Line level for edge n (n >= 1) of a frame described by v.
    function automatic logic wave(vec_t v, int n);
        if (n <= v.d)     return 1'b1;
        if (n == v.d + 1) return 1'b0;
        if (n == v.d + 2) return v.s[2];
        if (n == v.d + 3) return v.s[1];
        if (n == v.d + 4) return v.s[0];
        if (n == v.d + 5) return v.e;
        if (n <= v.d + 5 + v.b) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_frame(input vec_t v, input string name);
        int         done_at;
        int         busy_cnt;
        logic [4:0] fl;
        logic [2:0] st;
        done_at  = -1;
        busy_cnt = 0;
        fl = '0;
        st = '0;
        @(negedge clock);
        timeout_limit = 16'(v.lim);
        enable = 1'b1;
        dat_in = 1'b1;
        for (int n = 1; n <= v.d + v.b + 20 && done_at < 0; n++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n - 1;
                fl = {accepted, crc_err, write_err, frame_err, timeout_err};
                st = status;
            end else begin
                dat_in = wave(v, n);
            end
        end
        check({name, " done_edge"}, done_at, v.exp_done);
        check({name, " flags"}, int'(fl), int'(v.exp_flags));
        check({name, " status"}, int'(st), int'(v.exp_status));
        check({name, " busy_cycles"}, busy_cnt, v.exp_busy);
        // Enable stays high: results must hold and no new reception starts.
        for (int k = 0; k < 4; k++) begin
            dat_in = 1'($urandom);
            @(negedge clock);
        end
        check({name, " hold"}, int'({done, accepted, crc_err, write_err, frame_err, timeout_err}),
              int'({1'b1, v.exp_flags}));
        enable = 1'b0;
        dat_in = 1'b1;
        @(negedge clock);
        check({name, " clear"}, all_outs(), 0);
        @(negedge clock);
    endtask

    vec_t tbl [11];

    initial begin
        int pulses;
        reset = 1'b0;
        enable = 1'b0;
        dat_in = 1'b1;
        timeout_limit = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", all_outs(), 0);
        reset = 1'b1;
        @(negedge clock);

        //          d  s       e     b   lim flags     status  busy done
        tbl[0]  = mk(5, 3'b010, 1'b1, 20, 0,  5'b10000, 3'b010, 20,  31);
        tbl[1]  = mk(2, 3'b101, 1'b1, 3,  0,  5'b01000, 3'b101, 3,   11);
        tbl[2]  = mk(0, 3'b110, 1'b1, 0,  0,  5'b00100, 3'b110, 0,   6);
        tbl[3]  = mk(1, 3'b010, 1'b0, 0,  0,  5'b00010, 3'b010, 0,   6);
        tbl[4]  = mk(3, 3'b011, 1'b1, 2,  0,  5'b00010, 3'b011, 2,   11);
        tbl[5]  = mk(20, 3'b010, 1'b1, 0, 8,  5'b00001, 3'b000, 0,   9);
        tbl[6]  = mk(1, 3'b010, 1'b1, 50, 10, 5'b00001, 3'b010, 10,  17);
        tbl[7]  = mk(4, 3'b010, 1'b1, 1,  4,  5'b10000, 3'b010, 1,   11);
        tbl[8]  = mk(0, 3'b101, 1'b1, 3,  3,  5'b01000, 3'b101, 3,   9);
        tbl[9]  = mk(0, 3'b101, 1'b1, 4,  3,  5'b00001, 3'b101, 3,   9);
        tbl[10] = mk(2, 3'b110, 1'b1, 0,  1,  5'b00001, 3'b000, 0,   2);

        for (int i = 0; i < 11; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
        end

        // Stuck-high line with timeout disabled never completes.
        @(negedge clock);
        timeout_limit = '0;
        enable = 1'b1;
        dat_in = 1'b1;
        pulses = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("no_timeout_never_done", pulses, 0);
        enable = 1'b0;
        @(negedge clock);
        @(negedge clock);

        // Enable dropped in the middle of STATUS.
        pulses = 0;
        enable = 1'b1; dat_in = 1'b1;         // edge 0
        @(negedge clock); dat_in = 1'b0;      // start bit
        @(negedge clock); dat_in = 1'b0;      // status bit 2
        @(negedge clock); enable = 1'b0;      // abort
        @(negedge clock);
        check("abort_status_outs", all_outs(), 0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("abort_status_no_done", pulses, 0);
        run_frame(model(2, 3'b010, 1'b1, 4, 0), "after_abort");

        // Reset asserted in the middle of BUSY.
        enable = 1'b1; dat_in = 1'b1;
        @(negedge clock); dat_in = 1'b0;
        @(negedge clock); dat_in = 1'b0;
        @(negedge clock); dat_in = 1'b1;
        @(negedge clock); dat_in = 1'b0;
        @(negedge clock); dat_in = 1'b1;
        @(negedge clock); dat_in = 1'b0;
        repeat (3) @(negedge clock);
        check("busy_before_reset", int'(busy), 1);
        #2 reset = 1'b0;
        #1 check("async_reset_outs", all_outs(), 0);
        @(negedge clock);
        enable = 1'b0;
        reset = 1'b1;
        dat_in = 1'b1;
        @(negedge clock);
        check("after_reset_outs", all_outs(), 0);
        run_frame(model(0, 3'b101, 1'b1, 2, 0), "after_reset");

        // Randomized frames against the reference model.
        for (int i = 0; i < 40; i++) begin
            int         d, b, lim;
            logic [2:0] s;
            logic       e;
            d   = int'($urandom_range(0, 12));
            b   = int'($urandom_range(0, 15));
            s   = 3'($urandom);
            e   = ($urandom_range(0, 3) != 0);
            lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
            run_frame(model(d, s, e, b, lim), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
